// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a req/ready data-memory port, extends loads, and registers MEM/WB.
// Optional misalignment trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        RegWr_in,
  input  logic [1:0]  MemToReg_in,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] WriteData_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [4:0]  AddrC_in,
  input  logic [5:0]  Opcode_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        RegWr_out,
  output logic [1:0]  MemToReg_out,
  output logic [4:0]  AddrC_out,
  output logic [31:0] ALUOut_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] MemData_out,
  output logic        bus_err_out,
  output logic        misalign_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               regWr_q, regWr_d;
  logic [1:0]         memToReg_q, memToReg_d;
  logic [4:0]         addrC_q, addrC_d;
  logic [31:0]        aluOut_q, aluOut_d;
  logic [31:0]        pc4_q, pc4_d;
  logic [31:0]        memData_q, memData_d;
  logic               busErr_q, busErr_d;
  logic               misalign_q, misalign_d;

  logic               access, isLoad, signedLd, misTrap, reqInt, timeoutHit;
  size_e              size;
  logic [1:0]         a;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic [31:0]        extData;

  assign access    = MemRd_in | MemWr_in;
  assign isLoad    = MemRd_in & ~MemWr_in;
  assign a         = ALUOut_in[1:0];
  assign dmem_addr = {ALUOut_in[31:2], 2'b00};

  // Access size and signedness; unknown opcodes fall back to a full word.
  always_comb begin
    size     = SZ_WORD;
    signedLd = 1'b0;
    if (MemWr_in) begin
      case (Opcode_in)
        6'h28:   size = SZ_BYTE;
        6'h29:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end else begin
      case (Opcode_in)
        6'h20:   begin size = SZ_BYTE; signedLd = 1'b1; end
        6'h21:   begin size = SZ_HALF; signedLd = 1'b1; end
        6'h24:   size = SZ_BYTE;
        6'h25:   size = SZ_HALF;
        default: size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteData_in;
    case (size)
      SZ_BYTE: begin
        dmem_be    = 4'b0001 << a;
        dmem_wdata = {4{WriteData_in[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = a[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{WriteData_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (a)
      2'd0:    byteSel = dmem_rdata[7:0];
      2'd1:    byteSel = dmem_rdata[15:8];
      2'd2:    byteSel = dmem_rdata[23:16];
      default: byteSel = dmem_rdata[31:24];
    endcase
    halfSel = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size)
      SZ_BYTE: extData = {{24{signedLd & byteSel[7]}}, byteSel};
      SZ_HALF: extData = {{16{signedLd & halfSel[15]}}, halfSel};
      default: extData = dmem_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misTrap = access & (((size == SZ_HALF) & a[0]) | ((size == SZ_WORD) & (a != 2'd0)));
`else
  assign misTrap = 1'b0;
`endif

  // Reset gates the request so an in-flight access is dropped in the same cycle.
  assign reqInt     = access & ~misTrap & ~reset;
  assign timeoutHit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign dmem_req   = reqInt;
  assign dmem_we    = reqInt & MemWr_in;
  assign stall      = reqInt & ~dmem_ready & ~timeoutHit;

  always_comb begin
    state_d    = S_IDLE;
    cnt_d      = '0;
    regWr_d    = RegWr_in;
    memToReg_d = MemToReg_in;
    addrC_d    = AddrC_in;
    aluOut_d   = ALUOut_in;
    pc4_d      = pc_plus_4_in;
    memData_d  = '0;
    busErr_d   = 1'b0;
    misalign_d = 1'b0;
    if (reqInt) begin
      if (dmem_ready) begin
        memData_d = isLoad ? extData : 32'd0;
      end else if (timeoutHit) begin
        regWr_d  = 1'b0;
        busErr_d = 1'b1;
      end else begin
        state_d    = S_WAIT;
        cnt_d      = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        regWr_d    = 1'b0;
        memToReg_d = memToReg_q;
        addrC_d    = addrC_q;
        aluOut_d   = aluOut_q;
        pc4_d      = pc4_q;
        memData_d  = memData_q;
      end
    end else begin
      regWr_d    = RegWr_in & ~misTrap;
      misalign_d = misTrap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      regWr_q    <= 1'b0;
      memToReg_q <= '0;
      addrC_q    <= '0;
      aluOut_q   <= '0;
      pc4_q      <= '0;
      memData_q  <= '0;
      busErr_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regWr_q    <= regWr_d;
      memToReg_q <= memToReg_d;
      addrC_q    <= addrC_d;
      aluOut_q   <= aluOut_d;
      pc4_q      <= pc4_d;
      memData_q  <= memData_d;
      busErr_q   <= busErr_d;
      misalign_q <= misalign_d;
    end
  end

  assign RegWr_out     = regWr_q;
  assign MemToReg_out  = memToReg_q;
  assign AddrC_out     = addrC_q;
  assign ALUOut_out    = aluOut_q;
  assign pc_plus_4_out = pc4_q;
  assign MemData_out   = memData_q;
  assign bus_err_out   = busErr_q;
  assign misalign_out  = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written wait/timeout/reset/misalign
// sequences, and randomized transactions checked against a behavioural model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRd_in, MemWr_in, RegWr_in;
  logic [1:0]  MemToReg_in;
  logic [31:0] ALUOut_in, WriteData_in, pc_plus_4_in;
  logic [4:0]  AddrC_in;
  logic [5:0]  Opcode_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall, RegWr_out;
  logic [1:0]  MemToReg_out;
  logic [4:0]  AddrC_out;
  logic [31:0] ALUOut_out, pc_plus_4_out, MemData_out;
  logic        bus_err_out, misalign_out;

  int checks = 0;
  int failures = 0;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .MemRd_in(MemRd_in), .MemWr_in(MemWr_in), .RegWr_in(RegWr_in),
    .MemToReg_in(MemToReg_in), .ALUOut_in(ALUOut_in), .WriteData_in(WriteData_in),
    .pc_plus_4_in(pc_plus_4_in), .AddrC_in(AddrC_in), .Opcode_in(Opcode_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .RegWr_out(RegWr_out), .MemToReg_out(MemToReg_out),
    .AddrC_out(AddrC_out), .ALUOut_out(ALUOut_out), .pc_plus_4_out(pc_plus_4_out),
    .MemData_out(MemData_out), .bus_err_out(bus_err_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic rw, input logic [5:0] op,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rc);
    MemRd_in     = rd;
    MemWr_in     = wr;
    RegWr_in     = rw;
    Opcode_in    = op;
    ALUOut_in    = addr;
    WriteData_in = wd;
    AddrC_in     = rc;
    MemToReg_in  = {rd, 1'b0};
    pc_plus_4_in = addr ^ 32'h0040_0004;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sizeOf(input logic [5:0] op, input logic wr);
    if (wr) return (op == 6'h28) ? 1 : (op == 6'h29) ? 2 : 4;
    return (op == 6'h20 || op == 6'h24) ? 1 : (op == 6'h21 || op == 6'h25) ? 2 : 4;
  endfunction

  function automatic logic [3:0] modelBe(input logic [5:0] op, input logic wr, input logic [31:0] addr);
    int sz = sizeOf(op, wr);
    int off = int'(addr % 4);
    if (sz == 1) return 4'b0001 << off;
    if (sz == 2) return 4'b0011 << ((off / 2) * 2);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [5:0] op, input logic [31:0] wd);
    int sz = sizeOf(op, 1'b1);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    int sz = sizeOf(op, 1'b0);
    int off = int'(addr % 4);
    logic [31:0] v;
    if (sz == 4) return rdata;
    if (sz == 1) v = (rdata >> (8 * off)) & 32'hFF;
    else         v = (rdata >> (8 * ((off / 2) * 2))) & 32'hFFFF;
    if (op == 6'h20 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
    if (op == 6'h21 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic bit modelMis(input logic [5:0] op, input logic wr, input logic [31:0] addr);
    int sz = sizeOf(op, wr);
    return TRAP && ((sz == 2 && addr % 2 == 1) || (sz == 4 && addr % 4 != 0));
  endfunction

  // One transaction with the memory answering after lat wait cycles, checked against the model.
  task automatic runTxn(input logic rd, input logic wr, input logic rw, input logic [5:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rc,
                        input int lat, input logic [31:0] rdata, input string tag);
    bit acc = rd | wr;
    bit mis = acc && modelMis(op, wr, addr);
    applyStimulus(rd, wr, rw, op, addr, wd, rc);
    dmem_rdata = rdata;
    if (acc && !mis) begin
      for (int c = 0; c <= lat; c++) begin
        dmem_ready = (c == lat);
        #1;
        checkOutput({tag, " req"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, " stall"}, 32'(stall), 32'(c != lat));
        if (c == 0) begin
          checkOutput({tag, " we"}, 32'(dmem_we), 32'(wr));
          checkOutput({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
          checkOutput({tag, " be"}, 32'(dmem_be), 32'(modelBe(op, wr, addr)));
          if (wr) checkOutput({tag, " wdata"}, dmem_wdata, modelWdata(op, wd));
        end
        tick();
        if (c != lat) checkOutput({tag, " bubble"}, 32'(RegWr_out), 32'd0);
      end
      checkOutput({tag, " RegWr_out"}, 32'(RegWr_out), 32'(rw));
      checkOutput({tag, " MemData"}, MemData_out, (rd && !wr) ? modelLoad(op, addr, rdata) : 32'd0);
      checkOutput({tag, " AddrC"}, 32'(AddrC_out), 32'(rc));
      checkOutput({tag, " ALUOut"}, ALUOut_out, addr);
      checkOutput({tag, " busErr"}, 32'(bus_err_out), 32'd0);
    end else begin
      dmem_ready = 1'($urandom_range(0, 1));
      #1;
      checkOutput({tag, " idle req"}, 32'(dmem_req), 32'd0);
      checkOutput({tag, " idle stall"}, 32'(stall), 32'd0);
      tick();
      checkOutput({tag, " idle RegWr"}, 32'(RegWr_out), 32'(rw && !mis));
      checkOutput({tag, " idle MemData"}, MemData_out, 32'd0);
      checkOutput({tag, " misalign"}, 32'(misalign_out), 32'(mis));
      checkOutput({tag, " pc4"}, pc_plus_4_out, addr ^ 32'h0040_0004);
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] ops[8];
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    vecs[0] = '{6'h23, 1, 0, 32'h10, 32'h0,        32'h8899AABB, 4'hF, 32'h0,        32'h8899AABB};
    vecs[1] = '{6'h20, 1, 0, 32'h13, 32'h0,        32'h80FFFFFF, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{6'h24, 1, 0, 32'h13, 32'h0,        32'h80FFFFFF, 4'h8, 32'h0,        32'h00000080};
    vecs[3] = '{6'h21, 1, 0, 32'h12, 32'h0,        32'h80011234, 4'hC, 32'h0,        32'hFFFF8001};
    vecs[4] = '{6'h25, 1, 0, 32'h12, 32'h0,        32'h80011234, 4'hC, 32'h0,        32'h00008001};
    vecs[5] = '{6'h21, 1, 0, 32'h10, 32'h0,        32'h00007FFE, 4'h3, 32'h0,        32'h00007FFE};
    vecs[6] = '{6'h20, 1, 0, 32'h11, 32'h0,        32'h00007F00, 4'h2, 32'h0,        32'h0000007F};
    vecs[7] = '{6'h29, 0, 1, 32'h22, 32'h1234ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h0};
    vecs[8] = '{6'h28, 0, 1, 32'h21, 32'h000000A5, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[9] = '{6'h2B, 0, 1, 32'h40, 32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0};

    reset = 1'b1;
    applyStimulus(0, 0, 0, 6'h0, 32'h0, 32'h0, 5'd0);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    checkOutput("reset RegWr_out", 32'(RegWr_out), 32'd0);
    checkOutput("reset MemData", MemData_out, 32'd0);
    checkOutput("reset busErr", 32'(bus_err_out), 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, 1'b1, vecs[i].op, vecs[i].addr, vecs[i].wdata, 5'd7);
      dmem_rdata = vecs[i].rdata;
      dmem_ready = 1'b1;
      #1;
      checkOutput($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
      checkOutput($sformatf("vec%0d be", i), 32'(dmem_be), 32'(vecs[i].expBe));
      checkOutput($sformatf("vec%0d addr", i), dmem_addr, vecs[i].addr & 32'hFFFF_FFFC);
      checkOutput($sformatf("vec%0d we", i), 32'(dmem_we), 32'(vecs[i].wr));
      if (vecs[i].wr) checkOutput($sformatf("vec%0d wdata", i), dmem_wdata, vecs[i].expWdata);
      tick();
      checkOutput($sformatf("vec%0d MemData", i), MemData_out, vecs[i].expData);
      checkOutput($sformatf("vec%0d RegWr", i), 32'(RegWr_out), 32'd1);
    end
    dmem_ready = 1'b0;

    runTxn(1, 0, 1, 6'h20, 32'h13, 32'h0, 5'd3, 3, 32'h80FFFFFF, "lb wait3");
    runTxn(1, 0, 1, 6'h24, 32'h13, 32'h0, 5'd4, 3, 32'h80FFFFFF, "lbu wait3");

    // Store that never completes: 15 stalled cycles, then a one-cycle bus error.
    applyStimulus(0, 1, 1, 6'h2B, 32'h80, 32'h55AA55AA, 5'd9);
    dmem_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      #1;
      checkOutput($sformatf("timeout stall c%0d", c), 32'(stall), 32'd1);
      tick();
      checkOutput($sformatf("timeout bubble c%0d", c), 32'(RegWr_out), 32'd0);
      checkOutput($sformatf("timeout early busErr c%0d", c), 32'(bus_err_out), 32'd0);
    end
    #1;
    checkOutput("timeout last stall", 32'(stall), 32'd0);
    tick();
    checkOutput("timeout busErr", 32'(bus_err_out), 32'd1);
    checkOutput("timeout RegWr", 32'(RegWr_out), 32'd0);
    checkOutput("timeout MemData", MemData_out, 32'd0);
    applyStimulus(0, 0, 0, 6'h0, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("timeout busErr pulse end", 32'(bus_err_out), 32'd0);
    runTxn(1, 0, 1, 6'h23, 32'h44, 32'h0, 5'd2, 0, 32'h01020304, "after timeout");

    // Reset arriving while an access is waiting.
    applyStimulus(1, 0, 1, 6'h23, 32'h10, 32'h0, 5'd5);
    dmem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst mid req", 32'(dmem_req), 32'd0);
    checkOutput("rst mid stall", 32'(stall), 32'd0);
    checkOutput("rst mid RegWr", 32'(RegWr_out), 32'd0);
    checkOutput("rst mid ALUOut", ALUOut_out, 32'd0);
    checkOutput("rst mid pc4", pc_plus_4_out, 32'd0);
    tick();
    reset = 1'b0;
    runTxn(1, 0, 1, 6'h23, 32'h10, 32'h0, 5'd5, 1, 32'hCAFEF00D, "after reset");

    // Misaligned word store.
    applyStimulus(0, 1, 1, 6'h2B, 32'h101, 32'h11223344, 5'd6);
    dmem_ready = 1'b0;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    checkOutput("mis req", 32'(dmem_req), 32'd0);
    checkOutput("mis stall", 32'(stall), 32'd0);
    tick();
    checkOutput("mis pulse", 32'(misalign_out), 32'd1);
    checkOutput("mis RegWr", 32'(RegWr_out), 32'd0);
    applyStimulus(0, 0, 0, 6'h0, 32'h0, 32'h0, 5'd0);
    tick();
    checkOutput("mis pulse end", 32'(misalign_out), 32'd0);
`else
    checkOutput("mis be", 32'(dmem_be), 32'hF);
    checkOutput("mis addr", dmem_addr, 32'h100);
    checkOutput("mis req", 32'(dmem_req), 32'd1);
    dmem_ready = 1'b1;
    tick();
    checkOutput("mis no pulse", 32'(misalign_out), 32'd0);
    dmem_ready = 1'b0;
`endif

    for (int n = 0; n < 150; n++) begin
      int k = $urandom_range(0, 3);
      logic [5:0] op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      runTxn(1'(k == 1 || k == 3), 1'(k >= 2), 1'($urandom_range(0, 1)), op, $urandom, $urandom,
             5'($urandom), $urandom_range(0, 4), $urandom, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipelined CPU; sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives a variable-latency data-memory port with a req/ready handshake and byte lanes for sb/sh/sw.
- Sign/zero-extends lb/lh/lbu/lhu data, stalls the upstream pipeline while an access is outstanding, and registers results into the MEM/WB outputs.

Parameters:
TIMEOUT, 16, cycles an access may wait for dmem_ready before it is aborted (2..2^CNT_W-1)
CNT_W, 5, wait-counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
MemRd_in  in  1  load request from EX/MEM
MemWr_in  in  1  store request from EX/MEM
RegWr_in  in  1  register write enable from EX/MEM
MemToReg_in  in  2  writeback select from EX/MEM
ALUOut_in  in  32  effective address / ALU result
WriteData_in  in  32  store data (rt)
pc_plus_4_in  in  32  PC+4 from EX/MEM
AddrC_in  in  5  destination register
Opcode_in  in  6  instruction opcode
dmem_req  out  1  memory request, combinational
dmem_we  out  1  write strobe, combinational
dmem_addr  out  32  {ALUOut_in[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ready  in  1  access completes this cycle
dmem_rdata  in  32  read word, valid when dmem_ready=1
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational
RegWr_out, MemToReg_out[1:0], AddrC_out[4:0], ALUOut_out[31:0], pc_plus_4_out[31:0]  out  registered MEM/WB copies
MemData_out  out  32  extended load data, registered
bus_err_out  out  1  one-cycle pulse, registered: access timed out
misalign_out  out  1  one-cycle pulse, registered: misaligned access (see Optional Feature)

Behaviour:
- Reset: all registered outputs are 0; FSM=IDLE; counter=0. A reset asserted mid-access aborts the access immediately; dmem_req drops in the same cycle.
- access = MemRd_in|MemWr_in. If both are set, the access is a store.
- dmem_req = access && state in {IDLE,WAIT}. dmem_we = dmem_req && MemWr_in.
- Opcodes: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw. Any other opcode with MemRd/MemWr set is treated as lw/sw.
- Byte enables (a=ALUOut_in[1:0]):
  - sb: 4'b0001<<a; sh: a[1]?4'b1100:4'b0011; sw: 4'b1111.
  - Loads also drive the matching byte enables.
- dmem_wdata: sb {4{WriteData_in[7:0]}}; sh {2{WriteData_in[15:0]}}; sw WriteData_in.
- Load extend: select byte a (lb/lbu) or halfword a[1] (lh/lhu); sign-extend for lb/lh, zero-extend for lbu/lhu; lw passes the word unchanged.
- FSM:
  - IDLE, no access: no stall; MEM/WB captures inputs each cycle; MemData_out=0.
  - IDLE, access with dmem_ready=1: zero-wait completion; MEM/WB captures inputs plus extended dmem_rdata.
  - IDLE, access with dmem_ready=0: stall=1; go to WAIT; counter=1; MEM/WB loads a bubble (RegWr_out=0, other fields don't-care but held).
  - WAIT, dmem_ready=1: stall=0; capture MEM/WB as above; go to IDLE; counter=0.
  - WAIT, dmem_ready=0 and counter==TIMEOUT-1: abort. stall=0; MEM/WB captures with RegWr_out=0 and MemData_out=0; bus_err_out=1 for one cycle; go to IDLE. The upstream instruction retires as a no-op.
  - WAIT otherwise: stall=1; counter+1; bubble into MEM/WB.
- Inputs are held stable by upstream while stall=1; the block does not re-latch them.
- dmem_ready while dmem_req=0 is ignored.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned cases: lh/lhu/sh with a[0]=1; lw/sw (or default word) with a!=0.
  - Effect: dmem_req is suppressed, no stall, MEM/WB captures with RegWr_out=0, misalign_out pulses 1 for one cycle. Stores never reach memory.
- Undefined:
  - Misalignment is ignored: halfwords use a[1] only, words use the aligned address.
  - misalign_out is tied 0.

Test Plan:
- lw, ALUOut=0x10, dmem_ready=1 in the same cycle, rdata=0x8899AABB -> no stall; next edge MemData_out=0x8899AABB, RegWr_out=1.
- lb at 0x13, rdata=0x80FFFFFF, ready after 3 cycles -> stall high for exactly 3 cycles with RegWr_out=0 bubbles; then MemData_out=0xFFFFFF80. Repeat as lbu -> 0x00000080.
- sh at 0x22, WriteData=0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x20.
- Store with ready never asserted, TIMEOUT=16 -> stall high for 15 cycles, then bus_err_out pulse, RegWr_out=0, state back to IDLE.
- Reset asserted during WAIT -> dmem_req and stall drop immediately; all outputs 0; next access after reset completes normally.
- With MEM_MISALIGN_TRAP_EN defined, sw at 0x101 -> dmem_req stays 0, misalign_out=1 for one cycle, no stall. Without the macro: dmem_be=4'b1111, dmem_addr=0x100.
